// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide engine:
// M-op encodings, FSM states and operand signedness helpers.
package ex_muldiv_unit_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // MUL takes the low half, which is identical for signed and unsigned operands
    function automatic logic op_signed_a(md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic op_signed_b(md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side handshake of the multiply/divide engine: operands and op
// from ID/EX, stall/done/result back to the hazard logic and writeback.
interface ex_muldiv_unit_if #(
    parameter int unsigned XLEN = ex_muldiv_unit_pkg::XLEN
);
    logic            start_EXMD;
    logic [2:0]      op_EXMD;
    logic [XLEN-1:0] rs1_EXMD;
    logic [XLEN-1:0] rs2_EXMD;
    logic            flush_EXMD;
    logic            stall_EXMD;
    logic            done_EXMD;
    logic [XLEN-1:0] result_EXMD;

    modport master (
        output start_EXMD, op_EXMD, rs1_EXMD, rs2_EXMD, flush_EXMD,
        input  stall_EXMD, done_EXMD, result_EXMD
    );

    modport slave (
        input  start_EXMD, op_EXMD, rs1_EXMD, rs2_EXMD, flush_EXMD,
        output stall_EXMD, done_EXMD, result_EXMD
    );
endinterface

// File: rtl/ex_muldiv_unit_md_sign_fix.sv
// Two-lane conditional two's-complement negate; used for operand magnitudes
// on the way in and for product/quotient/remainder sign restoration on the way out.
module md_sign_fix #(
    parameter int unsigned WA = 32,
    parameter int unsigned WB = 32
) (
    input  logic [WA-1:0] i_a,
    input  logic [WB-1:0] i_b,
    input  logic          i_neg_a,
    input  logic          i_neg_b,
    output logic [WA-1:0] o_a,
    output logic [WB-1:0] o_b
);

    assign o_a = i_neg_a ? (~i_a + WA'(1)) : i_a;
    assign o_b = i_neg_b ? (~i_b + WB'(1)) : i_b;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide engine in EX; state advances on the
// falling clock edge like the pipeline registers, stalling the front end while busy.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = ex_muldiv_unit_pkg::XLEN
) (
    input  logic                 clk_EXMD,
    input  logic                 rst_n_EXMD,
    ex_muldiv_unit_if.slave      md
);

    localparam int unsigned CW = $clog2(XLEN + 1);

    md_state_e         r_state;
    md_state_e         w_next;
    md_op_e            r_op;
    md_op_e            w_op;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic [CW-1:0]     r_cnt;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_stall;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_corner;

    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_rem_sh;
    logic              w_ge;
    logic [XLEN-1:0]   w_diff;
    logic [2*XLEN-1:0] w_div_next;

    logic [2*XLEN-1:0] w_lane_a;
    logic [2*XLEN-1:0] w_fix_a;
    logic [XLEN-1:0]   w_fix_b;
    logic [XLEN-1:0]   w_result;

    assign w_op    = md_op_e'(md.op_EXMD);
    assign w_neg_a = op_signed_a(w_op) & md.rs1_EXMD[XLEN-1];
    assign w_neg_b = op_signed_b(w_op) & md.rs2_EXMD[XLEN-1];

    md_sign_fix #(.WA(XLEN), .WB(XLEN)) u_fix_in (
        .i_a     (md.rs1_EXMD),
        .i_b     (md.rs2_EXMD),
        .i_neg_a (w_neg_a),
        .i_neg_b (w_neg_b),
        .o_a     (w_abs_a),
        .o_b     (w_abs_b)
    );

    assign w_div_zero = w_op[2] && (md.rs2_EXMD == '0);
    assign w_div_ovf  = ((w_op == MD_DIV) || (w_op == MD_REM))
                        && (md.rs1_EXMD == {1'b1, {(XLEN-1){1'b0}}})
                        && (md.rs2_EXMD == '1);
    assign w_corner   = w_div_zero | w_div_ovf;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_stall  = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (md.start_EXMD && !md.flush_EXMD) begin
                    w_accept = 1'b1;
                    w_stall  = 1'b1;
                    w_next   = w_corner ? MD_DONE : MD_CALC;
                end
            end
            MD_CALC: begin
                w_stall = 1'b1;
                if (md.flush_EXMD)
                    w_next = MD_IDLE;
                else if (r_cnt == CW'(1))
                    w_next = MD_DONE;
            end
            MD_DONE: w_next = MD_IDLE;
            default: w_next = MD_IDLE;
        endcase
    end

    assign md.stall_EXMD = rst_n_EXMD & w_stall;

    // Multiply: shift-add with the multiplier in the low half of r_acc.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: restoring step; remainder in the high half, quotient shifts into the low half.
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_ge       = w_rem_sh >= {1'b0, r_b};
    assign w_diff     = w_rem_sh[XLEN-1:0] - r_b;
    assign w_div_next = {(w_ge ? w_diff : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};

    always_ff @(negedge clk_EXMD or negedge rst_n_EXMD) begin
        if (!rst_n_EXMD)
            r_state <= MD_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(negedge clk_EXMD or negedge rst_n_EXMD) begin
        if (!rst_n_EXMD) begin
            r_op      <= MD_MUL;
            r_acc     <= '0;
            r_b       <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (w_accept) begin
                        r_op  <= w_op;
                        r_cnt <= CW'(XLEN);
                        // Corner cases preload {remainder, quotient} so DONE reuses the normal result path.
                        if (w_div_zero) begin
                            r_acc     <= {md.rs1_EXMD, {XLEN{1'b1}}};
                            r_neg_res <= 1'b0;
                            r_neg_rem <= 1'b0;
                        end else if (w_div_ovf) begin
                            r_acc     <= {{XLEN{1'b0}}, md.rs1_EXMD};
                            r_neg_res <= 1'b0;
                            r_neg_rem <= 1'b0;
                        end else begin
                            r_acc     <= {{XLEN{1'b0}}, (w_op[2] ? w_abs_a : w_abs_b)};
                            r_b       <= w_op[2] ? w_abs_b : w_abs_a;
                            r_neg_res <= w_neg_a ^ w_neg_b;
                            r_neg_rem <= w_neg_a;
                        end
                    end
                end
                MD_CALC: begin
                    if (!md.flush_EXMD) begin
                        r_acc <= r_op[2] ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                MD_DONE: begin
                    if (!md.flush_EXMD) begin
                        r_done   <= 1'b1;
                        r_result <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_lane_a = r_op[2] ? {{XLEN{1'b0}}, r_acc[XLEN-1:0]} : r_acc;

    md_sign_fix #(.WA(2*XLEN), .WB(XLEN)) u_fix_out (
        .i_a     (w_lane_a),
        .i_b     (r_acc[2*XLEN-1:XLEN]),
        .i_neg_a (r_neg_res),
        .i_neg_b (r_neg_rem),
        .o_a     (w_fix_a),
        .o_b     (w_fix_b)
    );

    always_comb begin
        w_result = w_fix_a[XLEN-1:0];
        case (r_op)
            MD_MUL, MD_DIV, MD_DIVU:       w_result = w_fix_a[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  w_result = w_fix_a[2*XLEN-1:XLEN];
            MD_REM, MD_REMU:               w_result = w_fix_b;
            default:                       w_result = w_fix_a[XLEN-1:0];
        endcase
    end

    assign md.done_EXMD   = r_done;
    assign md.result_EXMD = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vectors with literal
// expectations plus a per-cycle comparison against an arithmetic reference model.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ex_muldiv_unit_if #(.XLEN(32)) md ();

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk_EXMD   (clk),
        .rst_n_EXMD (rst_n),
        .md         (md)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    function automatic logic [31:0] ref_md(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        int              ia = $signed(a);
        int              ib = $signed(b);
        logic [63:0]     p;
        logic [31:0]     r;
        r = '0;
        case (op)
            3'd0: begin p = sa * sb;          r = p[31:0];  end
            3'd1: begin p = sa * sb;          r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub;          r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib);
            3'd7: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        if (op[2] && b == 0) return 2;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Reference model: an accepted op produces its result L cycles later unless killed.
    bit          m_busy     = 0;
    int          m_left     = 0;
    bit          m_done_now = 0;
    logic [31:0] m_pend     = '0;
    logic [31:0] m_result   = '0;

    always @(posedge clk) begin
        logic exp_stall;
        if (!rst_n) begin
            check("rst_stall", {31'd0, md.stall_EXMD}, 32'd0);
            check("rst_done", {31'd0, md.done_EXMD}, 32'd0);
            check("rst_result", md.result_EXMD, 32'd0);
            m_busy = 0; m_left = 0; m_done_now = 0; m_result = '0;
        end else begin
            exp_stall = m_busy ? (m_left >= 2) : (md.start_EXMD && !md.flush_EXMD);
            check("stall", {31'd0, md.stall_EXMD}, {31'd0, exp_stall});
            check("done", {31'd0, md.done_EXMD}, {31'd0, m_done_now});
            check("result", md.result_EXMD, m_result);
            m_done_now = 0;
            if (m_busy) begin
                if (md.flush_EXMD) begin
                    m_busy = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 0;
                        m_done_now = 1;
                        m_result = m_pend;
                    end
                end
            end else if (md.start_EXMD && !md.flush_EXMD) begin
                m_busy = 1;
                m_left = ref_latency(md.op_EXMD, md.rs1_EXMD, md.rs2_EXMD) - 1;
                m_pend = ref_md(md.op_EXMD, md.rs1_EXMD, md.rs2_EXMD);
            end
        end
    end

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md.start_EXMD = s;
        md.op_EXMD    = op;
        md.rs1_EXMD   = a;
        md.rs2_EXMD   = b;
    endtask

    task automatic wait_done(input string name, input int from_k, input int lat, input logic [31:0] exp);
        int found = -1;
        for (int k = from_k; k <= from_k + 60; k++) begin
            @(posedge clk);
            if (md.done_EXMD) begin
                found = k;
                break;
            end
        end
        check({name, "_latency"}, 32'(found), 32'(lat));
        check({name, "_value"}, md.result_EXMD, exp);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        @(negedge clk); #1;
        drive(1'b1, op, a, b);
        @(negedge clk); #1;
        md.start_EXMD = 1'b0;
        wait_done(name, 1, lat, exp);
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        drive(1'b0, 3'd0, '0, '0);
        md.flush_EXMD = 1'b0;

        check("model_mul", ref_md(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("model_rem", ref_md(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("model_mulhsu", ref_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        check("reset_done", {31'd0, md.done_EXMD}, 32'd0);
        check("reset_result", md.result_EXMD, 32'd0);

        run_op("mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
        run_op("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
        run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
        run_op("divu_100_7",   3'd5, 32'd100,        32'd7,         32'd14,        34);
        run_op("remu_100_7",   3'd7, 32'd100,        32'd7,         32'd2,         34);
        run_op("div_by_zero",  3'd4, 32'd1234,       32'd0,         32'hFFFF_FFFF, 2);
        run_op("rem_by_zero",  3'd6, 32'd5,          32'd0,         32'd5,         2);
        run_op("div_overflow", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("rem_overflow", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2);

        // Flush in CALC cycle 10: the op dies silently, last result (0) survives.
        begin
            int n_done = 0;
            @(negedge clk); #1;
            drive(1'b1, 3'd0, 32'd7, 32'hFFFF_FFFD);
            @(negedge clk); #1;
            md.start_EXMD = 1'b0;
            repeat (9) @(negedge clk);
            #1 md.flush_EXMD = 1'b1;
            @(negedge clk); #1;
            md.flush_EXMD = 1'b0;
            @(posedge clk);
            check("flush_stall", {31'd0, md.stall_EXMD}, 32'd0);
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                if (md.done_EXMD) n_done++;
            end
            check("flush_no_done", 32'(n_done), 32'd0);
            check("flush_result_kept", md.result_EXMD, 32'd0);
        end
        run_op("divu_9_3", 3'd5, 32'd9, 32'd3, 32'd3, 34);

        // Reset in CALC cycle 5 clears outputs immediately.
        @(negedge clk); #1;
        drive(1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk); #1;
        md.start_EXMD = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_stall", {31'd0, md.stall_EXMD}, 32'd0);
        check("midrst_done", {31'd0, md.done_EXMD}, 32'd0);
        check("midrst_result", md.result_EXMD, 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        run_op("remu_after_rst", 3'd7, 32'd100, 32'd7, 32'd2, 34);

        // Back-to-back with start held: DONE ignores start, IDLE accepts the next op.
        @(negedge clk); #1;
        drive(1'b1, 3'd0, 32'd6, 32'd7);
        repeat (33) @(negedge clk);
        #1 drive(1'b1, 3'd5, 32'd100, 32'd7);
        @(posedge clk);
        check("b2b_no_early_done", {31'd0, md.done_EXMD}, 32'd0);
        @(negedge clk); #1;
        @(posedge clk);
        check("b2b_first_done", {31'd0, md.done_EXMD}, 32'd1);
        check("b2b_first_value", md.result_EXMD, 32'd42);
        @(negedge clk); #1;
        md.start_EXMD = 1'b0;
        wait_done("b2b_second", 35, 68, 32'd14);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
